// File: rtl/fila_arbiter.sv
// Arbiter and sequencer for the shared fila queue: two producers, one consumer,
// one queue operation at a time, with a local occupancy count guarding full/empty.
module fila_arbiter #(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    parameter int CW    = 4
) (
    input  logic          clk_10KHz,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [DW-1:0] p0_data,
    output logic          p0_ack,
    input  logic          p1_req,
    input  logic [DW-1:0] p1_data,
    output logic          p1_ack,
    input  logic          c_req,
    output logic          c_ack,
    output logic [DW-1:0] c_data,
    output logic [DW-1:0] q_data_in,
    output logic          q_enqueue,
    output logic          q_dequeue,
    input  logic [DW-1:0] q_data_out,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    typedef enum logic [1:0] {IDLE, ENQ, DEQ, RESP} state_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    state_t        state, next_state;
    logic          rr;
    logic          last_deq;
    logic          grant_p1;
    logic [DW-1:0] enq_data_r;
    logic [DW-1:0] c_data_r;
    logic [CW-1:0] count_r;
    logic          enq_ok, deq_ok, do_deq, do_enq, pick_p1;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign c_data    = c_data_r;
    assign q_data_in = enq_data_r;

    // On a tie the op type alternates; last_deq also records the op in flight.
    assign enq_ok  = (p0_req | p1_req) & ~full;
    assign deq_ok  = c_req & ~empty;
    assign do_deq  = deq_ok & (~enq_ok | ~last_deq);
    assign do_enq  = enq_ok & ~do_deq;
    assign pick_p1 = p1_req & (~p0_req | rr);

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (do_deq) begin
                    next_state = DEQ;
                end else if (do_enq) begin
                    next_state = ENQ;
                end
            end
            ENQ:     next_state = RESP;
            DEQ:     next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        q_enqueue = 1'b0;
        q_dequeue = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        c_ack     = 1'b0;
        case (state)
            ENQ:  q_enqueue = 1'b1;
            DEQ:  q_dequeue = 1'b1;
            RESP: begin
                c_ack  = last_deq;
                p0_ack = ~last_deq & ~grant_p1;
                p1_ack = ~last_deq & grant_p1;
            end
            default: ;
        endcase
    end

    // The head is sampled in DEQ, before the pop takes effect in the queue.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            rr         <= 1'b0;
            last_deq   <= 1'b0;
            grant_p1   <= 1'b0;
            enq_data_r <= '0;
            c_data_r   <= '0;
            count_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_deq) begin
                        last_deq <= 1'b1;
                    end else if (do_enq) begin
                        last_deq   <= 1'b0;
                        grant_p1   <= pick_p1;
                        rr         <= ~pick_p1;
                        enq_data_r <= pick_p1 ? p1_data : p0_data;
                    end
                end
                ENQ: count_r <= count_r + CW'(1);
                DEQ: begin
                    c_data_r <= q_data_out;
                    count_r  <= count_r - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
